// File: rtl/img_rsz_div_sched_pkg.sv
// Shared types and default sizing for the resizer divider scheduler.
package img_rsz_div_pkg;

   localparam int DEF_NUM_REQ       = 4;
   localparam int DEF_NUMINATOR_W   = 40;
   localparam int DEF_DENOMINATOR_W = 32;
   localparam int DEF_QUOTIENT_W    = 8;

   // Answer returned for a zero denominator: largest representable quotient.
   localparam logic [DEF_QUOTIENT_W-1:0] DEF_QUOT_SAT = '1;

   typedef enum logic [1:0] {
      Idle_s,
      Issue_s,
      Wait_s,
      ZeroRsp_s
   } div_state_e;

endpackage

// File: rtl/img_rsz_div_sched_if.sv
// Requester and divider handshake bundle for img_rsz_div_sched.
// slave is the scheduler's view; master is the surrounding environment.
interface img_rsz_div_sched_if
   import img_rsz_div_pkg::*;
#(
   parameter int NUM_REQ       = DEF_NUM_REQ,
   parameter int NUMINATOR_W   = DEF_NUMINATOR_W,
   parameter int DENOMINATOR_W = DEF_DENOMINATOR_W,
   parameter int QUOTIENT_W    = DEF_QUOTIENT_W
);

   // requester side
   logic [NUM_REQ-1:0]               ReqVld;
   logic [NUM_REQ-1:0]               ReqRdy;
   logic [NUM_REQ*NUMINATOR_W-1:0]   ReqNum;
   logic [NUM_REQ*DENOMINATOR_W-1:0] ReqDen;
   logic [NUM_REQ-1:0]               RspVld;
   logic [NUM_REQ-1:0]               RspRdy;
   logic [QUOTIENT_W-1:0]            RspQuot;

   // divider side
   logic [NUMINATOR_W-1:0]           DivNum;
   logic [DENOMINATOR_W-1:0]         DivDen;
   logic                             DivBwVld;
   logic                             DivBwRdy;
   logic [QUOTIENT_W-1:0]            DivQuot;
   logic                             DivFwVld;
   logic                             DivFwRdy;

   modport slave (
      input  ReqVld, ReqNum, ReqDen, RspRdy, DivBwRdy, DivQuot, DivFwVld,
      output ReqRdy, RspVld, RspQuot, DivNum, DivDen, DivBwVld, DivFwRdy
   );

   modport master (
      output ReqVld, ReqNum, ReqDen, RspRdy, DivBwRdy, DivQuot, DivFwVld,
      input  ReqRdy, RspVld, RspQuot, DivNum, DivDen, DivBwVld, DivFwRdy
   );

endinterface

// File: rtl/img_rsz_div_sched_rr_arb.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping at N. Works for any N >= 2, power of two or not.
module img_rsz_rr_arb #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_vld
);

   // Scan N positions starting at ptr; the sum is one bit wider so the
   // wrap subtraction never overflows.
   always_comb begin
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] j;
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      sum     = '0;
      j       = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(N))
            sum = sum - (IDX_W+1)'(N);
         j = sum[IDX_W-1:0];
         if (!gnt_vld && req[j]) begin
            gnt_vld = 1'b1;
            gnt[j]  = 1'b1;
            gnt_idx = j;
         end
      end
   end

endmodule

// File: rtl/img_rsz_div_sched.sv
// Shares one divider between NUM_REQ requesters. Round-robin grant,
// operands latched and issued to the divider, quotient passed straight
// back to the owner. Zero denominators are answered locally (saturated).
module img_rsz_div_sched
   import img_rsz_div_pkg::*;
#(
   parameter int NUM_REQ       = DEF_NUM_REQ,
   parameter int NUMINATOR_W   = DEF_NUMINATOR_W,
   parameter int DENOMINATOR_W = DEF_DENOMINATOR_W,
   parameter int QUOTIENT_W    = DEF_QUOTIENT_W
) (
   input  logic                Clk,
   input  logic                RstN,
   img_rsz_div_sched_if.slave  bus
);

   localparam int REQ_IDX_W = $clog2(NUM_REQ);
   localparam logic [QUOTIENT_W-1:0] QUOT_SAT = {QUOTIENT_W{1'b1}};

   div_state_e                 state_q, state_d;
   logic [REQ_IDX_W-1:0]       ptr_q, ptr_d;
   logic [REQ_IDX_W-1:0]       owner_q, owner_d;
   logic [NUMINATOR_W-1:0]     num_q, num_d;
   logic [DENOMINATOR_W-1:0]   den_q, den_d;

   logic [NUM_REQ-1:0]                    gnt;
   logic [REQ_IDX_W-1:0]                  gnt_idx;
   logic                                  gnt_vld;
   logic [NUM_REQ-1:0][NUMINATOR_W-1:0]   req_num;
   logic [NUM_REQ-1:0][DENOMINATOR_W-1:0] req_den;

   logic [NUM_REQ-1:0]    req_rdy, rsp_vld;
   logic [QUOTIENT_W-1:0] rsp_quot;
   logic                  div_bw_vld, div_fw_rdy;

   assign req_num = bus.ReqNum;
   assign req_den = bus.ReqDen;

   img_rsz_rr_arb #(
      .N     (NUM_REQ),
      .IDX_W (REQ_IDX_W)
   ) u_arb (
      .req     (bus.ReqVld),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   // Pointer value after owner completes: the next requester gets first pick.
   function automatic logic [REQ_IDX_W-1:0] idx_inc(input logic [REQ_IDX_W-1:0] i);
      return (i == REQ_IDX_W'(NUM_REQ-1)) ? '0 : i + 1'b1;
   endfunction

   // State and operand registers.
   always_ff @(posedge Clk) begin
      if (!RstN) begin
         state_q <= Idle_s;
         ptr_q   <= '0;
         owner_q <= '0;
         num_q   <= '0;
         den_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         num_q   <= num_d;
         den_q   <= den_d;
      end
   end

   // Next state and handshake outputs.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      num_d      = num_q;
      den_d      = den_q;
      req_rdy    = '0;
      rsp_vld    = '0;
      rsp_quot   = '0;
      div_bw_vld = 1'b0;
      div_fw_rdy = 1'b0;
      case (state_q)
         Idle_s: begin
            if (gnt_vld) begin
               req_rdy = gnt;
               owner_d = gnt_idx;
               num_d   = req_num[gnt_idx];
               den_d   = req_den[gnt_idx];
               state_d = (req_den[gnt_idx] == '0) ? ZeroRsp_s : Issue_s;
            end
         end
         Issue_s: begin
            div_bw_vld = 1'b1;
            if (bus.DivBwRdy)
               state_d = Wait_s;
         end
         Wait_s: begin
            // zero-latency pass-through; only the owner's ready matters
            rsp_vld[owner_q] = bus.DivFwVld;
            rsp_quot         = bus.DivQuot;
            div_fw_rdy       = bus.RspRdy[owner_q];
            if (bus.DivFwVld && bus.RspRdy[owner_q]) begin
               state_d = Idle_s;
               ptr_d   = idx_inc(owner_q);
            end
         end
         ZeroRsp_s: begin
            rsp_vld[owner_q] = 1'b1;
            rsp_quot         = QUOT_SAT;
            if (bus.RspRdy[owner_q]) begin
               state_d = Idle_s;
               ptr_d   = idx_inc(owner_q);
            end
         end
         default: state_d = Idle_s;
      endcase
   end

   // Combinational outputs are forced low while reset is held so nothing
   // leaks out from the pre-reset state or from live requests.
   assign bus.ReqRdy   = RstN ? req_rdy    : '0;
   assign bus.RspVld   = RstN ? rsp_vld    : '0;
   assign bus.RspQuot  = RstN ? rsp_quot   : '0;
   assign bus.DivBwVld = RstN ? div_bw_vld : 1'b0;
   assign bus.DivFwRdy = RstN ? div_fw_rdy : 1'b0;
   assign bus.DivNum   = num_q;
   assign bus.DivDen   = den_q;

endmodule

// File: tb/tb_img_rsz_div_sched.sv
// Directed bench for img_rsz_div_sched with a small divider model.
module tb_img_rsz_div_sched;
   import img_rsz_div_pkg::*;

   localparam int NR = 4;
   localparam int NW = 40;
   localparam int DW = 32;
   localparam int QW = 8;

   logic Clk = 1'b0;
   logic RstN;
   int   checks = 0;
   int   errors = 0;

   logic [NR-1:0][NW-1:0] num_a;
   logic [NR-1:0][DW-1:0] den_a;

   img_rsz_div_sched_if #(.NUM_REQ(NR), .NUMINATOR_W(NW), .DENOMINATOR_W(DW), .QUOTIENT_W(QW)) bus ();

   img_rsz_div_sched #(.NUM_REQ(NR), .NUMINATOR_W(NW), .DENOMINATOR_W(DW), .QUOTIENT_W(QW)) dut (
      .Clk  (Clk),
      .RstN (RstN),
      .bus  (bus)
   );

   assign bus.ReqNum = num_a;
   assign bus.ReqDen = den_a;

   always #5 Clk = ~Clk;

   // Divider model: accepts operands, returns num/den bfm_lat cycles later,
   // holds the result until DivFwRdy.
   int          bfm_lat = 9;
   int          bfm_cnt;
   logic        bfm_busy;
   logic [QW-1:0] bfm_q;
   always @(posedge Clk) begin
      if (!RstN) begin
         bfm_busy     <= 1'b0;
         bfm_cnt      <= 0;
         bfm_q        <= '0;
         bus.DivFwVld <= 1'b0;
         bus.DivQuot  <= '0;
      end else if (bus.DivFwVld) begin
         if (bus.DivFwRdy) bus.DivFwVld <= 1'b0;
      end else if (bfm_busy) begin
         if (bfm_cnt <= 1) begin
            bus.DivFwVld <= 1'b1;
            bus.DivQuot  <= bfm_q;
            bfm_busy     <= 1'b0;
         end else begin
            bfm_cnt <= bfm_cnt - 1;
         end
      end else if (bus.DivBwVld && bus.DivBwRdy) begin
         bfm_busy <= 1'b1;
         bfm_cnt  <= bfm_lat;
         bfm_q    <= QW'(bus.DivNum / NW'(bus.DivDen));
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // From posedge+1: wait (bounded) for RspVld == one-hot g; returns at negedge.
   task automatic wait_rsp(input int g, output int n);
      logic found;
      found = 1'b0;
      n = 0;
      while (!found && n < 60) begin
         @(negedge Clk);
         if (bus.RspVld == NR'(64'(1) << g)) found = 1'b1;
         else begin
            @(posedge Clk); #1;
            n++;
         end
      end
      chk($sformatf("rsp_seen_%0d", g), 64'(found), 64'd1);
   endtask

   // From posedge+1 in an Idle cycle where ReqVld makes g the winner.
   // Assumes DivBwRdy=1 and RspRdy[g]=1. Returns at posedge+1 back in Idle.
   task automatic run_txn(input int g, input logic [QW-1:0] q, input int lat);
      int n;
      @(negedge Clk);
      chk($sformatf("grant_%0d", g), 64'(bus.ReqRdy), 64'(1) << g);
      chk("bw_vld_idle", 64'(bus.DivBwVld), 64'd0);
      @(posedge Clk); #1;
      @(negedge Clk);
      chk("bw_vld_issue", 64'(bus.DivBwVld), 64'd1);
      chk("rdy_issue", 64'(bus.ReqRdy), 64'd0);
      chk("div_num", 64'(bus.DivNum), 64'(num_a[g]));
      chk("div_den", 64'(bus.DivDen), 64'(den_a[g]));
      @(posedge Clk); #1;
      wait_rsp(g, n);
      chk("rsp_lat", 64'(n), 64'(lat));
      chk($sformatf("rsp_quot_%0d", g), 64'(bus.RspQuot), 64'(q));
      chk("fw_vld", 64'(bus.DivFwVld), 64'd1);
      chk("fw_rdy", 64'(bus.DivFwRdy), 64'd1);
      @(posedge Clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      logic found;

      // ---- reset ----
      RstN         = 1'b0;
      bus.ReqVld   = '1;
      bus.RspRdy   = '1;
      bus.DivBwRdy = 1'b1;
      for (int i = 0; i < NR; i++) begin
         num_a[i] = NW'(7*i + 3);
         den_a[i] = DW'(7);
      end
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("rst_req_rdy", 64'(bus.ReqRdy), 64'd0);
      @(posedge Clk); #1;
      bus.ReqVld = '0;
      RstN = 1'b1;
      @(negedge Clk);
      chk("rst_rsp_vld", 64'(bus.RspVld), 64'd0);
      chk("rst_bw_vld", 64'(bus.DivBwVld), 64'd0);
      chk("rst_fw_rdy", 64'(bus.DivFwRdy), 64'd0);
      chk("rst_quot", 64'(bus.RspQuot), 64'd0);
      chk("rst_num", 64'(bus.DivNum), 64'd0);
      chk("rst_den", 64'(bus.DivDen), 64'd0);
      @(posedge Clk); #1;

      // ---- all requesters valid: 0,1,2,3,0,1,2,3; quotient = index ----
      bfm_lat = 2;
      bus.ReqVld = '1;
      for (int t = 0; t < 8; t++) run_txn(t % NR, QW'(t % NR), 2);
      bus.ReqVld = '0;

      // ---- single request on 2: 1000/10 = 0x64 after 9 cycles ----
      bfm_lat  = 9;
      num_a[2] = NW'(1000);
      den_a[2] = DW'(10);
      bus.ReqVld = 4'b0100;
      run_txn(2, 8'h64, 9);
      bus.ReqVld = '0;

      // ---- zero denominator on 1 (pointer is 3, wraps to 1) ----
      num_a[1] = NW'(55);
      den_a[1] = '0;
      bus.ReqVld = 4'b0010;
      @(negedge Clk);
      chk("zero_grant", 64'(bus.ReqRdy), 64'b0010);
      @(posedge Clk); #1;
      bus.ReqVld = '0;
      @(negedge Clk);
      chk("zero_rsp_vld", 64'(bus.RspVld), 64'b0010);
      chk("zero_quot", 64'(bus.RspQuot), 64'hFF);
      chk("zero_no_bw", 64'(bus.DivBwVld), 64'd0);
      @(posedge Clk); #1;
      @(negedge Clk);
      chk("zero_done", 64'(bus.RspVld), 64'd0);
      chk("zero_no_bw2", 64'(bus.DivBwVld), 64'd0);
      @(posedge Clk); #1;
      // pointer now 2: with 0,1,2 requesting, 2 must win
      den_a[1] = DW'(7);
      num_a[1] = NW'(10);
      bfm_lat  = 3;
      bus.ReqVld = 4'b0111;
      run_txn(2, 8'h64, 3);
      bus.ReqVld = '0;

      // ---- backpressure on req 3 (pointer 3) ----
      num_a[3] = NW'(4000);
      den_a[3] = DW'(40);
      num_a[0] = NW'(3);
      den_a[0] = DW'(7);
      bus.DivBwRdy = 1'b0;
      bus.ReqVld = 4'b1001;
      @(negedge Clk);
      chk("bp_grant", 64'(bus.ReqRdy), 64'b1000);
      @(posedge Clk); #1;
      bus.ReqVld = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         chk("bp_bw_vld", 64'(bus.DivBwVld), 64'd1);
         chk("bp_num", 64'(bus.DivNum), 64'd4000);
         chk("bp_den", 64'(bus.DivDen), 64'd40);
         chk("bp_no_grant", 64'(bus.ReqRdy), 64'd0);
         @(posedge Clk); #1;
      end
      bus.DivBwRdy = 1'b1;
      bus.RspRdy = 4'b0111;
      @(negedge Clk);
      chk("bp_bw_vld_acc", 64'(bus.DivBwVld), 64'd1);
      @(posedge Clk); #1;
      wait_rsp(3, n);
      chk("bp_rsp_lat", 64'(n), 64'd3);
      for (int i = 0; i < 7; i++) begin
         chk("bp_rsp_hold", 64'(bus.RspVld), 64'b1000);
         chk("bp_quot_hold", 64'(bus.RspQuot), 64'h64);
         chk("bp_fw_rdy_low", 64'(bus.DivFwRdy), 64'd0);
         chk("bp_no_grant2", 64'(bus.ReqRdy), 64'd0);
         @(posedge Clk); #1;
         @(negedge Clk);
      end
      bus.RspRdy = '1;
      #1;
      chk("bp_fw_rdy_high", 64'(bus.DivFwRdy), 64'd1);
      chk("bp_rsp_last", 64'(bus.RspVld), 64'b1000);
      @(posedge Clk); #1;
      run_txn(0, 8'h00, 3);
      bus.ReqVld = '0;

      // ---- reset during Wait_s (pointer 1) ----
      bfm_lat = 9;
      bus.ReqVld = 4'b0100;
      @(negedge Clk);
      chk("rw_grant", 64'(bus.ReqRdy), 64'b0100);
      @(posedge Clk); #1;
      bus.ReqVld = '0;
      @(posedge Clk); #1;
      repeat (3) @(posedge Clk);
      #1;
      @(negedge Clk);
      chk("rw_waiting", 64'(bus.RspVld), 64'd0);
      @(posedge Clk); #1;
      RstN = 1'b0;
      @(posedge Clk); #1;
      RstN = 1'b1;
      @(negedge Clk);
      chk("rw_req_rdy", 64'(bus.ReqRdy), 64'd0);
      chk("rw_rsp_vld", 64'(bus.RspVld), 64'd0);
      chk("rw_bw_vld", 64'(bus.DivBwVld), 64'd0);
      chk("rw_fw_rdy", 64'(bus.DivFwRdy), 64'd0);
      chk("rw_quot", 64'(bus.RspQuot), 64'd0);
      chk("rw_num", 64'(bus.DivNum), 64'd0);
      chk("rw_den", 64'(bus.DivDen), 64'd0);
      @(posedge Clk); #1;
      for (int i = 0; i < 12; i++) begin
         @(negedge Clk);
         chk("rw_no_rsp", 64'(bus.RspVld), 64'd0);
         @(posedge Clk); #1;
      end
      bfm_lat = 3;
      bus.ReqVld = 4'b1001;
      run_txn(0, 8'h00, 3);
      bus.ReqVld = 4'b1000;
      run_txn(3, 8'h64, 3);
      bus.ReqVld = '0;

      // ---- non-owner noise while owner 2 waits (pointer 0) ----
      num_a[2] = NW'(300);
      den_a[2] = DW'(3);
      num_a[1] = NW'(10);
      den_a[1] = DW'(7);
      bfm_lat  = 6;
      bus.ReqVld = 4'b0100;
      @(negedge Clk);
      chk("nz_grant", 64'(bus.ReqRdy), 64'b0100);
      @(posedge Clk); #1;
      bus.ReqVld = 4'b0010;
      @(negedge Clk);
      chk("nz_issue_rdy", 64'(bus.ReqRdy), 64'd0);
      chk("nz_issue_vld", 64'(bus.DivBwVld), 64'd1);
      chk("nz_issue_num", 64'(bus.DivNum), 64'd300);
      @(posedge Clk); #1;
      found = 1'b0;
      n = 0;
      while (!found && n < 40) begin
         bus.RspRdy[0] = ~bus.RspRdy[0];
         @(negedge Clk);
         if (bus.RspVld == 4'b0100) found = 1'b1;
         else begin
            chk("nz_no_grant", 64'(bus.ReqRdy), 64'd0);
            chk("nz_no_rsp", 64'(bus.RspVld), 64'd0);
            @(posedge Clk); #1;
            n++;
         end
      end
      chk("nz_rsp_seen", 64'(found), 64'd1);
      chk("nz_rsp_lat", 64'(n), 64'd6);
      chk("nz_quot", 64'(bus.RspQuot), 64'h64);
      @(posedge Clk); #1;
      bus.RspRdy = '1;
      run_txn(1, 8'h01, 6);
      bus.ReqVld = '0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
